// File: rtl/chain_solver_core.sv
// Chain relaxation core: holds NODES points and advances one frame per accepted start.
// Each frame applies one gravity step, then ITERS x PHASES phased neighbour-averaging passes.
module chain_solver_core #(
  parameter int                NODES   = 8,
  parameter int                W       = 32,
  parameter int                PHASES  = 2,
  parameter int                ITERS   = 4,
  parameter int                SPACING = 16,
  parameter int                GRAVITY = 1,
  parameter logic signed [W-1:0] Y_MAX = {1'b0, {(W-1){1'b1}}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pin_first,
  input  logic                 is_last,
  input  logic signed [W-1:0]  prev_last_x,
  input  logic signed [W-1:0]  prev_last_y,
  input  logic signed [W-1:0]  next_first_x,
  input  logic signed [W-1:0]  next_first_y,
  input  logic signed [W-1:0]  x_mouse,
  input  logic signed [W-1:0]  y_mouse,
  output logic                 busy,
  output logic                 done,
  output logic [NODES*W-1:0]   nodes_x,
  output logic [NODES*W-1:0]   nodes_y,
  output logic [1:0]           dbg_state
);
  // Handshake: start is taken only in IDLE; busy is high from the accepting edge until the
  // frame returns to IDLE; done pulses for exactly the last busy cycle. Starts while busy are dropped.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRAVITY = 2'd1, S_RELAX = 2'd2, S_DONE = 2'd3} state_t;

  localparam int SW = W + 2;
  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic signed [SW-1:0] YMAX_W = SW'(Y_MAX);
  localparam logic signed [SW-1:0] GRAV_W = SW'(GRAVITY);

  state_t                r_state, w_next_state;
  logic [PW-1:0]         r_phase;
  logic [IW-1:0]         r_iter;
  logic signed [W-1:0]   r_x [NODES];
  logic signed [W-1:0]   r_y [NODES];
  logic signed [W-1:0]   r_prev_x, r_prev_y, r_next_x, r_next_y, r_mouse_x, r_mouse_y;
  logic                  r_pin, r_last;
  logic signed [W-1:0]   w_ext_x [NODES+2];
  logic signed [W-1:0]   w_ext_y [NODES+2];
  logic signed [W-1:0]   w_rx [NODES];
  logic signed [W-1:0]   w_ry [NODES];
  logic signed [W-1:0]   w_gy [NODES];
  logic                  w_last_step;

  function automatic logic signed [W-1:0] sat_y(input logic signed [SW-1:0] v);
    if (v > YMAX_W) return Y_MAX;
    return v[W-1:0];
  endfunction

  function automatic logic signed [SW-1:0] avg3(input logic signed [W-1:0] l,
                                                 input logic signed [W-1:0] p,
                                                 input logic signed [W-1:0] r);
    logic signed [SW-1:0] s;
    s = SW'(l) + (SW'(p) <<< 1) + SW'(r);
    return s >>> 2;
  endfunction

  function automatic logic signed [SW-1:0] avg2(input logic signed [W-1:0] l,
                                                 input logic signed [W-1:0] p);
    logic signed [SW-1:0] s;
    s = SW'(l) + SW'(p);
    return s >>> 1;
  endfunction

  // Neighbour view with the latched boundary points at both ends.
  always_comb begin
    w_ext_x[0]       = r_prev_x;
    w_ext_y[0]       = r_prev_y;
    w_ext_x[NODES+1] = r_next_x;
    w_ext_y[NODES+1] = r_next_y;
    for (int i = 0; i < NODES; i++) begin
      w_ext_x[i+1] = r_x[i];
      w_ext_y[i+1] = r_y[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      w_rx[i] = r_x[i];
      w_ry[i] = r_y[i];
      w_gy[i] = sat_y(SW'(r_y[i]) + GRAV_W);
      if ((i % PHASES) == int'(r_phase) && !(i == 0 && r_pin)) begin
        if (i == NODES - 1 && r_last) begin
          w_rx[i] = W'(avg2(w_ext_x[i], w_ext_x[i+1]));
          w_ry[i] = sat_y(avg2(w_ext_y[i], w_ext_y[i+1]));
        end else begin
          w_rx[i] = W'(avg3(w_ext_x[i], w_ext_x[i+1], w_ext_x[i+2]));
          w_ry[i] = sat_y(avg3(w_ext_y[i], w_ext_y[i+1], w_ext_y[i+2]));
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_last_step  = (r_phase == PW'(PHASES - 1)) && (r_iter == IW'(ITERS - 1));
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_GRAVITY;
      S_GRAVITY: w_next_state = S_RELAX;
      S_RELAX:   if (w_last_step) w_next_state = S_DONE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_iter    <= '0;
      r_prev_x  <= '0;
      r_prev_y  <= '0;
      r_next_x  <= '0;
      r_next_y  <= '0;
      r_mouse_x <= '0;
      r_mouse_y <= '0;
      r_pin     <= 1'b0;
      r_last    <= 1'b0;
      for (int i = 0; i < NODES; i++) begin
        r_x[i] <= W'(i * SPACING);
        r_y[i] <= '0;
      end
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: if (start) begin
          r_prev_x  <= prev_last_x;
          r_prev_y  <= prev_last_y;
          r_next_x  <= next_first_x;
          r_next_y  <= next_first_y;
          r_mouse_x <= x_mouse;
          r_mouse_y <= y_mouse;
          r_pin     <= pin_first;
          r_last    <= is_last;
        end
        S_GRAVITY: begin
          for (int i = 0; i < NODES; i++)
            if (!(i == 0 && r_pin)) r_y[i] <= w_gy[i];
          if (r_pin) begin
            r_x[0] <= r_mouse_x;
            r_y[0] <= sat_y(SW'(r_mouse_y));
          end
          r_phase <= '0;
          r_iter  <= '0;
        end
        S_RELAX: begin
          for (int i = 0; i < NODES; i++) begin
            r_x[i] <= w_rx[i];
            r_y[i] <= w_ry[i];
          end
          if (r_phase == PW'(PHASES - 1)) begin
            r_phase <= '0;
            r_iter  <= r_iter + 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nodes_x = '0;
    nodes_y = '0;
    for (int i = 0; i < NODES; i++) begin
      nodes_x[i*W +: W] = r_x[i];
      nodes_y[i*W +: W] = r_y[i];
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_chain_solver_core.sv
// Directed bench for chain_solver_core: instance a (4 nodes, 2 phases) and instance b
// (4 phases, GRAVITY=5, Y_MAX=2), expected values worked out by hand.
module tb_chain_solver_core;
  logic                clk, reset, start_a, start_b, pin_first, is_last;
  logic signed [31:0]  prev_last_x, prev_last_y, next_first_x, next_first_y, x_mouse, y_mouse;
  logic                busy_a, done_a, busy_b, done_b;
  logic [127:0]        nodes_x_a, nodes_y_a, nodes_x_b, nodes_y_b;
  logic [1:0]          dbg_state_a, dbg_state_b;

  int                  n_compared = 0;
  int                  n_mismatched = 0;
  logic [31:0]         exp_q[$];
  logic [31:0]         snap_a_x0, snap_a_y0;
  logic [127:0]        snap_b_y;
  int                  lat, cnt;

  chain_solver_core #(.NODES(4), .W(32), .PHASES(2), .ITERS(1), .SPACING(16), .GRAVITY(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .pin_first(pin_first), .is_last(is_last),
    .prev_last_x(prev_last_x), .prev_last_y(prev_last_y),
    .next_first_x(next_first_x), .next_first_y(next_first_y),
    .x_mouse(x_mouse), .y_mouse(y_mouse), .busy(busy_a), .done(done_a),
    .nodes_x(nodes_x_a), .nodes_y(nodes_y_a), .dbg_state(dbg_state_a)
  );

  chain_solver_core #(.NODES(4), .W(32), .PHASES(4), .ITERS(1), .SPACING(16), .GRAVITY(5),
                      .Y_MAX(32'sd2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .pin_first(pin_first), .is_last(is_last),
    .prev_last_x(prev_last_x), .prev_last_y(prev_last_y),
    .next_first_x(next_first_x), .next_first_y(next_first_y),
    .x_mouse(x_mouse), .y_mouse(y_mouse), .busy(busy_b), .done(done_b),
    .nodes_x(nodes_x_b), .nodes_y(nodes_y_b), .dbg_state(dbg_state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [127:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  task automatic push4(input logic [31:0] e0, e1, e2, e3);
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3);
  endtask

  task automatic check_nodes(input string tag, input logic [127:0] v);
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check_val($sformatf("%s[%0d]", tag, i), lane(v, i), e);
    end
  endtask

  // driver: one frame, returns cycles from start cycle to done (0 on timeout)
  task automatic run_frame(input bit use_b, output int l);
    l = 0;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (k == 2) begin
        snap_a_x0 = lane(nodes_x_a, 0);
        snap_a_y0 = lane(nodes_y_a, 0);
        snap_b_y  = nodes_y_b;
      end
      if (use_b ? done_b : done_a) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; pin_first = 1'b1; is_last = 1'b0;
    prev_last_x = 0; prev_last_y = 0; next_first_x = 64; next_first_y = 0;
    x_mouse = 0; y_mouse = 0;

    // reset state
    do_reset();
    check_val("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check_val("rst_done_a", {31'd0, done_a}, 32'd0);
    check_val("rst_busy_b", {31'd0, busy_b}, 32'd0);
    push4(0, 16, 32, 48); check_nodes("rst_x_a", nodes_x_a);
    push4(0, 0, 0, 0);    check_nodes("rst_y_a", nodes_y_a);
    push4(0, 16, 32, 48); check_nodes("rst_x_b", nodes_x_b);

    // pinned head, interior tail
    run_frame(1'b0, lat);
    check_val("f1_latency", lat, 32'd4);
    check_val("f1_busy_in_done", {31'd0, busy_a}, 32'd1);
    push4(0, 16, 32, 48); check_nodes("f1_x", nodes_x_a);
    push4(0, 0, 1, 0);    check_nodes("f1_y", nodes_y_a);
    @(negedge clk);
    check_val("f1_idle_busy", {31'd0, busy_a}, 32'd0);
    check_val("f1_idle_done", {31'd0, done_a}, 32'd0);

    // chain tail rule
    do_reset();
    is_last = 1'b1;
    run_frame(1'b0, lat);
    check_val("f2_latency", lat, 32'd4);
    push4(0, 16, 32, 40); check_nodes("f2_x", nodes_x_a);
    push4(0, 0, 1, 1);    check_nodes("f2_y", nodes_y_a);

    // negative mouse target, signed averaging
    do_reset();
    is_last = 1'b0; x_mouse = -8; y_mouse = -8;
    run_frame(1'b0, lat);
    check_val("f3_grav_x0", snap_a_x0, 32'hFFFF_FFF8);
    check_val("f3_grav_y0", snap_a_y0, 32'hFFFF_FFF8);
    check_val("f3_x0", lane(nodes_x_a, 0), 32'hFFFF_FFF8);
    check_val("f3_x1", lane(nodes_x_a, 1), 32'd14);
    check_val("f3_y1", lane(nodes_y_a, 1), 32'hFFFF_FFFE);

    // saturation on instance b, sequential phases
    do_reset();
    pin_first = 1'b0; next_first_x = 0; next_first_y = 0; x_mouse = 0; y_mouse = 0;
    run_frame(1'b1, lat);
    check_val("f4_latency", lat, 32'd6);
    check_val("f4_a_idle", {31'd0, busy_a}, 32'd0);
    push4(2, 2, 2, 2);    check_nodes("f4_grav_y", snap_b_y);
    push4(4, 17, 32, 32); check_nodes("f4_x", nodes_x_b);
    push4(1, 1, 1, 1);    check_nodes("f4_y", nodes_y_b);

    // start while busy is dropped
    do_reset();
    pin_first = 1'b1; next_first_x = 64;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done_a) cnt++;
      @(negedge clk);
    end
    check_val("busy_start_dones", cnt, 32'd1);

    // reset mid-RELAX aborts
    do_reset();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    check_val("abort_in_relax", {30'd0, dbg_state_a}, 32'd2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_val("abort_busy", {31'd0, busy_a}, 32'd0);
    check_val("abort_done", {31'd0, done_a}, 32'd0);
    push4(0, 16, 32, 48); check_nodes("abort_x", nodes_x_a);
    push4(0, 0, 0, 0);    check_nodes("abort_y", nodes_y_a);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
    check_val("abort_no_done", cnt, 32'd0);

    // start held: ignored in DONE, taken in the next IDLE cycle
    do_reset();
    @(negedge clk); start_a = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_a) begin lat = k; break; end
    end
    check_val("b2b_latency1", lat, 32'd4);
    @(negedge clk);
    check_val("b2b_idle_gap", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    check_val("b2b_accepted", {31'd0, busy_a}, 32'd1);
    start_a = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_a) begin lat = k; break; end
    end
    check_val("b2b_latency2", lat, 32'd3);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
